// File: rtl/baud_tick_generator_pkg.sv
// uart_pkg: shared UART timing defaults and common divisor values
// Holds the default widths and the divisors that give 9600 and 115200 baud
// from a 50 MHz system clock at 16x oversampling.
package uart_pkg;
  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DIV_WIDTH_DEFAULT = 16;
  localparam int DIV_9600_50MHZ = 325;
  localparam int DIV_115200_50MHZ = 27;
endpackage

// File: rtl/baud_tick_generator_tick_prescaler.sv
// tick_prescaler: divisor shadow plus prescaler that strobes Wrap once per sample period
// Ports: Clk, Reset (async, active high), Enable (count while high),
//        Restart (sync clear and shadow reload), Divisor (cycles per sample, 0 acts as 1),
//        Wrap (combinational, high on the cycle the prescaler wraps).
module tick_prescaler
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 Restart,
  input  logic [DIV_WIDTH-1:0] Divisor,
  output logic                 Wrap
);
  logic [DIV_WIDTH-1:0] shadow, cnt, eff;
  logic load_pending;
  always_comb eff = (shadow == '0) ? DIV_WIDTH'(1) : shadow;
  // Shadow only changes at period boundaries, so a new Divisor never bends the running period.
  assign Wrap = Enable && !Restart && !load_pending && cnt == eff - DIV_WIDTH'(1);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      cnt <= '0;
      shadow <= '0;
      load_pending <= 1'b1;
    end else if (load_pending || Restart) begin
      cnt <= '0;
      shadow <= Divisor;
      load_pending <= 1'b0;
    end else if (Wrap) begin
      cnt <= '0;
      shadow <= Divisor;
    end else if (Enable) begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
endmodule

// File: rtl/baud_tick_generator.sv
// baud_tick_generator: UART sample, mid-bit and bit strobes from a programmable divisor
// Ports: Clk, Reset (async, active high), Enable, Restart (start-bit alignment),
//        Divisor (cycles per sample strobe), Sample_Tick / Mid_Tick / Bit_Tick
//        (registered one-cycle strobes).
module baud_tick_generator
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = DIV_WIDTH_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int OS_WIDTH   = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 Restart,
  input  logic [DIV_WIDTH-1:0] Divisor,
  output logic                 Sample_Tick,
  output logic                 Mid_Tick,
  output logic                 Bit_Tick
);
  localparam logic [OS_WIDTH-1:0] OS_MID = OS_WIDTH'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_WIDTH-1:0] OS_LAST = OS_WIDTH'(OVERSAMPLE - 1);
  logic wrap;
  logic [OS_WIDTH-1:0] os_cnt;
  tick_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
    .Clk(Clk),
    .Reset(Reset),
    .Enable(Enable),
    .Restart(Restart),
    .Divisor(Divisor),
    .Wrap(wrap)
  );
  // wrap is already low under Restart, so the strobes clear without extra gating.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      os_cnt <= '0;
      Sample_Tick <= 1'b0;
      Mid_Tick <= 1'b0;
      Bit_Tick <= 1'b0;
    end else begin
      os_cnt <= Restart ? '0 : wrap ? (os_cnt == OS_LAST ? '0 : os_cnt + OS_WIDTH'(1)) : os_cnt;
      Sample_Tick <= wrap;
      Mid_Tick <= wrap && os_cnt == OS_MID;
      Bit_Tick <= wrap && os_cnt == OS_LAST;
    end
endmodule

// File: tb/tb_baud_tick_generator.sv
// tb_baud_tick_generator: directed and random checks of baud_tick_generator against a period-level model
module tb_baud_tick_generator;
  localparam int OS = 16;
  logic Clk, Reset, Enable, Restart;
  logic [15:0] Divisor;
  logic Sample_Tick, Mid_Tick, Bit_Tick;
  int total = 0, bad = 0;
  int el, per, nsam;
  bit pend;
  logic es, em, eb;
  logic [15:0] rdiv;

  baud_tick_generator dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Restart(Restart), .Divisor(Divisor),
    .Sample_Tick(Sample_Tick), .Mid_Tick(Mid_Tick), .Bit_Tick(Bit_Tick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Model: a sample period lasts `per` enabled cycles; nsam counts sample strobes since alignment.
  task automatic model(input logic en, input logic rs, input logic [15:0] div);
    es = 1'b0; em = 1'b0; eb = 1'b0;
    if (pend || rs) begin
      pend = 0;
      el = 0;
      per = (div == 0) ? 1 : int'(div);
      if (rs) nsam = 0;
    end else if (en) begin
      el++;
      if (el == per) begin
        el = 0;
        per = (div == 0) ? 1 : int'(div);
        nsam++;
        es = 1'b1;
        em = (nsam % OS) == OS / 2;
        eb = (nsam % OS) == 0;
      end
    end
  endtask

  task automatic model_reset();
    pend = 1; el = 0; per = 1; nsam = 0;
    es = 1'b0; em = 1'b0; eb = 1'b0;
  endtask

  task automatic step(input logic en, input logic rs, input logic [15:0] div);
    Enable = en; Restart = rs; Divisor = div;
    @(posedge Clk);
    model(en, rs, div);
    #1;
    chk("sample", Sample_Tick, es);
    chk("mid", Mid_Tick, em);
    chk("bit", Bit_Tick, eb);
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; Restart = 1'b0; Divisor = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_sample", Sample_Tick, 1'b0);
    chk("rst_mid", Mid_Tick, 1'b0);
    chk("rst_bit", Bit_Tick, 1'b0);
    Reset = 1'b0;
    // divisor 3, restart on the load edge
    step(1, 1, 16'd3);
    for (int i = 1; i <= 100; i++) begin
      step(1, 0, 16'd3);
      if (i == 3) chk("d3_first_sample", Sample_Tick, 1'b1);
      if (i == 4) chk("d3_sample_width", Sample_Tick, 1'b0);
      if (i == 24) chk("d3_mid24", Mid_Tick, 1'b1);
      if (i == 48 || i == 96) chk("d3_bit", Bit_Tick, 1'b1);
      if (i == 49) chk("d3_bit_width", Bit_Tick, 1'b0);
    end
    // divisor 0 then 1: sample strobe every cycle
    for (int i = 1; i <= 40; i++) step(1, 0, 16'd0);
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 16'd1);
      if (i == 20) chk("d1_continuous", Sample_Tick, 1'b1);
    end
    // divisor 10 changed to 4 mid-period
    step(1, 1, 16'd10);
    for (int i = 1; i <= 30; i++) begin
      step(1, 0, (i <= 5) ? 16'd10 : 16'd4);
      if (i == 9) chk("chg_no_early", Sample_Tick, 1'b0);
      if (i == 10 || i == 14 || i == 18) chk("chg_sample", Sample_Tick, 1'b1);
    end
    // enable held low at prescaler 2
    step(1, 1, 16'd5);
    step(1, 0, 16'd5);
    step(1, 0, 16'd5);
    for (int i = 1; i <= 7; i++) step(0, 0, 16'd5);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 16'd5);
      if (i == 2) chk("en_no_early", Sample_Tick, 1'b0);
      if (i == 3) chk("en_resume", Sample_Tick, 1'b1);
    end
    // restart at os_cnt 11 on a would-be wrap
    step(1, 1, 16'd2);
    for (int i = 1; i <= 23; i++) step(1, 0, 16'd2);
    step(1, 1, 16'd2);
    chk("rs_wrap_suppressed", Sample_Tick, 1'b0);
    for (int i = 1; i <= 34; i++) begin
      step(1, 0, 16'd2);
      if (i == 16) chk("rs_mid", Mid_Tick, 1'b1);
      if (i == 32) chk("rs_bit", Bit_Tick, 1'b1);
    end
    // asynchronous reset mid-bit
    for (int i = 1; i <= 9; i++) step(1, 0, 16'd3);
    #3 Reset = 1'b1;
    #1;
    model_reset();
    chk("arst_sample", Sample_Tick, 1'b0);
    chk("arst_mid", Mid_Tick, 1'b0);
    chk("arst_bit", Bit_Tick, 1'b0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    step(1, 0, 16'd3);
    for (int i = 1; i <= 30; i++) begin
      step(1, 0, 16'd3);
      if (i == 2) chk("arst_no_early", Sample_Tick, 1'b0);
      if (i == 3) chk("arst_first", Sample_Tick, 1'b1);
    end
    // random traffic
    rdiv = 16'd2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) rdiv = 16'($urandom_range(0, 6));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 149) == 0, rdiv);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
